// File: rtl/mcpu_wb_sequencer.sv
// Write-back sequencer for MCPU_Registerfile: arbitrates EX/LD writes onto the single write port,
// frames regsetwb with stable operands and keeps a pending-write scoreboard for hazard checks.
module mcpu_wb_sequencer #(
    parameter int unsigned WORD_SIZE         = 16,
    parameter int unsigned OPERAND_SIZE      = 4,
    parameter int unsigned REGS_NUMBER_WIDTH = 4,
    localparam int unsigned REGISTERS_NUMBER = 1 << REGS_NUMBER_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ex_valid,
    output logic                        ex_ready,
    input  logic [OPERAND_SIZE-1:0]     ex_dst,
    input  logic [OPERAND_SIZE-1:0]     ex_src,
    input  logic [1:0]                  ex_cmd,
    input  logic [WORD_SIZE-1:0]        ex_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [OPERAND_SIZE-1:0]     ld_dst,
    input  logic [WORD_SIZE-1:0]        ld_data,
    input  logic                        rsv_valid,
    input  logic [OPERAND_SIZE-1:0]     rsv_reg,
    input  logic [OPERAND_SIZE-1:0]     chk_a,
    input  logic [OPERAND_SIZE-1:0]     chk_b,
    output logic                        hazard,
    output logic [REGISTERS_NUMBER-1:0] busy,
    output logic                        wb_active,
    output logic [OPERAND_SIZE-1:0]     wb_op1,
    output logic [OPERAND_SIZE-1:0]     wb_op2,
    output logic [1:0]                  wb_cmd,
    output logic [WORD_SIZE-1:0]        wb_data,
    output logic                        regsetwb
);

    localparam logic [1:0] CMD_NORMAL = 2'd0;
    localparam logic [1:0] CMD_MOV    = 2'd1;
    localparam logic [1:0] CMD_LOAD   = 2'd2;
    localparam logic [1:0] CMD_NOP    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t                        state;
    logic                          ld_pref;
    logic                          grant_ex;
    logic                          grant_ld;
    logic                          ex_nop;
    logic [REGISTERS_NUMBER-1:0]   busy_next;
    logic [REGS_NUMBER_WIDTH-1:0]  wb_idx;
    logic [REGS_NUMBER_WIDTH-1:0]  ex_idx;
    logic [REGS_NUMBER_WIDTH-1:0]  rsv_idx;
    logic [REGS_NUMBER_WIDTH-1:0]  chk_a_idx;
    logic [REGS_NUMBER_WIDTH-1:0]  chk_b_idx;

    assign wb_idx    = wb_op1[REGS_NUMBER_WIDTH-1:0];
    assign ex_idx    = ex_dst[REGS_NUMBER_WIDTH-1:0];
    assign rsv_idx   = rsv_reg[REGS_NUMBER_WIDTH-1:0];
    assign chk_a_idx = chk_a[REGS_NUMBER_WIDTH-1:0];
    assign chk_b_idx = chk_b[REGS_NUMBER_WIDTH-1:0];

    // Round-robin grant: on conflict the requester not served last wins.
    always_comb begin
        grant_ex = 1'b0;
        grant_ld = 1'b0;
        if (state == ST_IDLE) begin
            grant_ex = ex_valid && (!ld_valid || !ld_pref);
            grant_ld = ld_valid && (!ex_valid || ld_pref);
        end
    end

    assign ex_ready = grant_ex;
    assign ld_ready = grant_ld;
    assign ex_nop   = grant_ex && (ex_cmd == CMD_NOP);
    assign hazard   = busy[chk_a_idx] | busy[chk_b_idx];

    // Scoreboard update: retirements clear first so a same-edge reservation wins.
    always_comb begin
        busy_next = busy;
        if (state == ST_HOLD) begin
            busy_next[wb_idx] = 1'b0;
        end
        if (ex_nop) begin
            busy_next[ex_idx] = 1'b0;
        end
        if (rsv_valid) begin
            busy_next[rsv_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ld_pref   <= 1'b0;
            busy      <= '0;
            wb_active <= 1'b0;
            wb_op1    <= '0;
            wb_op2    <= '0;
            wb_cmd    <= CMD_NOP;
            wb_data   <= '0;
            regsetwb  <= 1'b0;
        end else begin
            busy <= busy_next;
            case (state)
                ST_IDLE: begin
                    if (grant_ex) begin
                        ld_pref <= 1'b1;
                        // DO_NOTHING only retires the scoreboard entry; port stays untouched.
                        if (!ex_nop) begin
                            state     <= ST_SETUP;
                            wb_active <= 1'b1;
                            wb_op1    <= ex_dst;
                            wb_op2    <= ex_src;
                            wb_cmd    <= (ex_cmd == CMD_MOV) ? CMD_MOV : CMD_NORMAL;
                            wb_data   <= ex_data;
                        end
                    end else if (grant_ld) begin
                        ld_pref   <= 1'b0;
                        state     <= ST_SETUP;
                        wb_active <= 1'b1;
                        wb_op1    <= ld_dst;
                        wb_op2    <= '0;
                        wb_cmd    <= CMD_LOAD;
                        wb_data   <= ld_data;
                    end
                end
                ST_SETUP: begin
                    state    <= ST_STROBE;
                    regsetwb <= 1'b1;
                end
                ST_STROBE: begin
                    state    <= ST_HOLD;
                    regsetwb <= 1'b0;
                end
                ST_HOLD: begin
                    state     <= ST_IDLE;
                    wb_active <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
